// File: rtl/cdc_event_arbiter_pkg.sv
// rtl/cdc_event_arbiter_pkg.sv - shared types, latency limits and round-robin pick for cdc_event_arbiter
package cdc_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int LAT_MIN = 2;
    localparam int LAT_MAX = 3;
    localparam int MAX_NCH = 16;

    function automatic bit lat_legal(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

    // First set bit of req searching upward from last+1 with wrap; -1 when req is empty.
    // Iterating from the far end lets the nearest candidate overwrite the others.
    function automatic int rr_pick(input logic [MAX_NCH-1:0] req, input int nch, input int last);
        int pick;
        pick = -1;
        for (int k = MAX_NCH; k >= 1; k--) begin
            if ((k <= nch) && req[(last + k) % nch]) begin
                pick = (last + k) % nch;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cdc_event_arbiter_if.sv
// rtl/cdc_event_arbiter_if.sv - granted-word valid/ready output bundle of cdc_event_arbiter
interface cdc_event_arbiter_if #(
    parameter int NCH = 4,
    parameter int DW  = 8
);
    import cdc_arb_pkg::*;

    localparam int CW = $clog2(NCH);

    logic          OUT_VALID;
    logic          OUT_READY;
    logic [CW-1:0] OUT_CH;
    logic [DW-1:0] OUT_DATA;

    modport master (
        output OUT_VALID,
        output OUT_CH,
        output OUT_DATA,
        input  OUT_READY
    );

    modport slave (
        input  OUT_VALID,
        input  OUT_CH,
        input  OUT_DATA,
        output OUT_READY
    );

endinterface

// File: rtl/cdc_event_arbiter_sync_chain.sv
// rtl/cdc_event_arbiter_sync_chain.sv - LATENCY-deep single-bit synchronizer with programmable reset value
module sync_chain #(
    parameter int   LATENCY = 2,
    parameter logic INIT    = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q
);

    logic [LATENCY-1:0] stage_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stage_q <= {LATENCY{INIT}};
        end else begin
            stage_q <= {stage_q[LATENCY-2:0], D};
        end
    end

    assign Q = stage_q[LATENCY-1];

endmodule

// File: rtl/cdc_event_arbiter.sv
// rtl/cdc_event_arbiter.sv - toggle-handshake receiver: synchronize, edge-detect, round-robin onto one valid/ready output
module cdc_event_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int   NCH     = 4,
    parameter int   DW      = 8,
    parameter int   LATENCY = 2,
    parameter logic INIT    = 1'b0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NCH-1:0]      REQ_TGL,
    input  logic [NCH*DW-1:0]   DATA_ASYNC,
    output logic [NCH-1:0]      ACK_TGL,
    cdc_event_arbiter_if.master out_if,
    output logic [NCH-1:0]      PEND,
    output logic [NCH-1:0]      OVERRUN,
    input  logic                ERR_CLR
);

    localparam int CW = $clog2(NCH);

    if (!lat_legal(LATENCY)) begin : g_bad_latency
        $error("cdc_event_arbiter: LATENCY must be 2 or 3");
    end
    if ((NCH < 2) || (NCH > MAX_NCH)) begin : g_bad_nch
        $error("cdc_event_arbiter: NCH must be in 2..16");
    end

    logic [NCH-1:0] sync_last;
    logic [NCH-1:0] hist_q;
    logic [NCH-1:0] evt;
    logic [NCH-1:0] held;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] pend_q,  pend_d;
    logic [NCH-1:0] ovr_q,   ovr_d;
    logic [NCH-1:0] ack_q,   ack_d;
    logic           valid_q, valid_d;
    logic [CW-1:0]  ch_q,    ch_d;
    logic [CW-1:0]  last_q,  last_d;
    logic [DW-1:0]  data_q,  data_d;
    state_e         state_q, state_d;

    int             pick_idx;
    logic           pick_ok;
    logic [CW-1:0]  pick_ch;
    logic           fire;
    logic           grant;

    for (genvar i = 0; i < NCH; i++) begin : g_sync
        sync_chain #(
            .LATENCY (LATENCY),
            .INIT    (INIT)
        ) u_sync (
            .CLK   (CLK),
            .RST_N (RST_N),
            .D     (REQ_TGL[i]),
            .Q     (sync_last[i])
        );
    end

    assign evt      = sync_last ^ hist_q;
    assign fire     = valid_q & out_if.OUT_READY;
    assign pick_idx = rr_pick(MAX_NCH'(pend_q), NCH, int'(last_q));
    assign pick_ok  = (pick_idx >= 0);
    assign pick_ch  = CW'(pick_idx);

    // A channel whose word sits on the output is still owed its ack, so it counts as busy.
    always_comb begin
        held = '0;
        if (valid_q) begin
            held[ch_q] = 1'b1;
        end
        busy = pend_q | held;
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ch_d    = ch_q;
        data_d  = data_q;
        last_d  = last_q;
        ack_d   = ack_q;
        grant   = 1'b0;
        pend_d  = pend_q | (evt & ~busy);
        ovr_d   = (ERR_CLR ? '0 : ovr_q) | (evt & busy);

        case (state_q)
            IDLE: begin
                grant = pick_ok;
            end
            HOLD: begin
                if (fire) begin
                    ack_d[ch_q] = ~ack_q[ch_q];
                    grant       = pick_ok;
                    if (!pick_ok) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Grant from the registered pending set; new events join on the next cycle.
        if (grant) begin
            valid_d         = 1'b1;
            ch_d            = pick_ch;
            data_d          = DATA_ASYNC[pick_ch*DW +: DW];
            pend_d[pick_ch] = 1'b0;
            last_d          = pick_ch;
            state_d         = HOLD;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hist_q  <= {NCH{INIT}};
            pend_q  <= '0;
            ovr_q   <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            data_q  <= '0;
            last_q  <= CW'(NCH - 1);
            state_q <= IDLE;
        end else begin
            hist_q  <= sync_last;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            last_q  <= last_d;
            state_q <= state_d;
        end
    end

    assign ACK_TGL         = ack_q;
    assign PEND            = pend_q;
    assign OVERRUN         = ovr_q;
    assign out_if.OUT_VALID = valid_q;
    assign out_if.OUT_CH    = ch_q;
    assign out_if.OUT_DATA  = data_q;

endmodule
